// File: rtl/sumador_restador_serial_pkg.sv
// sumador_restador_serial_pkg: shared state encoding and op codes for the bit-serial adder/subtractor.
// Revision: 1.0
`default_nettype none

package sumador_restador_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sumador_restador_serial_cell.sv
// sumadorCompleto: one-bit full-adder cell (sum and carry out of a + b + cin).
// Revision: 1.0
`default_nettype none

module sumadorCompleto (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/sumador_restador_serial.sv
// sumador_restador_serial: N-bit bit-serial adder/subtractor, LSB first, with start/done handshake.
// Revision: 1.0
`default_nettype none

module sumador_restador_serial
  import sumador_restador_serial_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         overflow
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_PEN  = CW'(N - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  sa_q, sa_d;
  logic [N-1:0]  sb_q, sb_d;
  logic [N-1:0]  result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          c_msb_in_q, c_msb_in_d;
  logic          cout_q, cout_d;
  logic          overflow_q, overflow_d;

  logic cell_s;
  logic cell_co;

  sumadorCompleto u_cell (
    .a   (sa_q[0]),
    .b   (sb_q[0]),
    .cin (carry_q),
    .s   (cell_s),
    .co  (cell_co)
  );

  always_comb begin
    state_d    = state_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    result_d   = result_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    c_msb_in_d = c_msb_in_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;

    case (state_q)
      SHIFT: begin
        result_d = {cell_s, result_q[N-1:1]};
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        carry_d  = cell_co;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_PEN) begin
          c_msb_in_d = cell_co;
        end
        if (cnt_q == CNT_LAST) begin
          state_d    = DONE;
          cout_d     = cell_co;
          overflow_d = c_msb_in_q ^ cell_co;
        end
      end
      default: begin
        // IDLE and DONE both accept a new operation, giving back-to-back throughput.
        if (start) begin
          sa_d    = a;
          sb_d    = b ^ {N{op}};
          carry_d = op;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sa_q       <= '0;
      sb_q       <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      c_msb_in_q <= 1'b0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      result_q   <= result_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      c_msb_in_q <= c_msb_in_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: doc/sumador_restador_serial.md
Name: sumador_restador_serial

Overview:
- Bit-serial N-bit adder/subtractor built around the team's one-bit full-adder cell. It processes one bit per clock, LSB first.
- Sits directly upstream of that cell. It owns the operand shift registers, the carry flip-flop and the sequencing FSM, and feeds the cell one bit pair plus carry each cycle.
- Delivers a parallel result with carry-out, signed overflow and a start/done handshake.

Parameters:
N, 4, operand/result width in bits (N >= 2)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a new operation; sampled only when not busy
op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
a  input  N  operand A; sampled with start
b  input  N  operand B; sampled with start
busy  output  1  high while bits are being processed
done  output  1  single-cycle pulse when the result is valid
result  output  N  sum/difference; held stable until the next accepted start
cout  output  1  carry out of MSB; for subtract, 1 = no borrow (a >= b unsigned)
overflow  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (async, rst=1), applied immediately:
  - state=IDLE, busy=0, done=0, result=0, cout=0, overflow=0.
  - Shift registers, carry flip-flop and bit counter cleared.
- Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at rising edge k, accept the operation:
    - load sa<=a, sb<=b XOR {N{op}}, carry<=op, cnt<=0, state<=SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (busy=1), one bit per edge:
  - Cell inputs: a=sa[0], b=sb[0], cin=carry.
  - Each edge: result shifts right with cell sum entering result[N-1]; sa and sb shift right; carry<=cell co; cnt<=cnt+1.
  - On the edge where cnt==N-2: capture the cell co as c_msb_in (carry into the MSB).
  - On the edge where cnt==N-1: state<=DONE, cout<=cell co, overflow<=c_msb_in XOR cell co.
- Bit sequence: bit i is processed at edge k+1+i. The final bit is at edge k+N.
- DONE: done=1 and busy=0 for exactly one cycle (the cycle after edge k+N), then next state is IDLE.
  - A start sampled while in DONE is accepted exactly as in IDLE (back-to-back operation, no idle gap).
- Latency: done is high N cycles after the start edge. Throughput is one operation per N+1 cycles.
- start while busy=1 is ignored. a, b and op may change freely during SHIFT with no effect.
- result, cout and overflow keep their final values through DONE and IDLE until the next accepted start.
  - They are not cleared at start; result is shifted during SHIFT and is only meaningful when done=1 or afterwards.
- Arithmetic is modulo 2^N. Subtract is a + ~b + 1 (the +1 comes from carry initialised to op).
- cnt width: $clog2(N) bits; it never wraps inside an operation.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and op codes (OP_ADD=1'b0, OP_SUB=1'b1).
- Single sub-module: the existing one-bit full-adder cell sumadorCompleto, instantiated once for the per-bit sum/carry.
- All registers and the FSM live in sumador_restador_serial.

Test Plan:
- N=4, op=0, a=5, b=3, start pulse -> done exactly 4 cycles after the start edge; result=4'b1000, cout=0, overflow=1.
- op=1, a=7, b=2 -> result=4'b0101, cout=1, overflow=0; op=1, a=2, b=7 -> result=4'b1011, cout=0, overflow=0.
- op=0, a=15, b=1 -> result=0, cout=1, overflow=0; done pulse width exactly 1 cycle; result held for 10 idle cycles.
- Change a/b/op and pulse start during SHIFT -> ignored, first result unaffected; start in the DONE cycle -> second operation accepted, its done arrives N+1 cycles after the first done.
- Assert rst asynchronously (between edges) during the 2nd SHIFT cycle -> all outputs 0 immediately, no done pulse; the next start after release completes normally with the correct result.
- Exhaustive N=4 sweep of all a, b, op against a reference model -> result, cout and overflow match on every done.
